// File: rtl/snd_mailbox_pkg.sv
// Shared slot map and status layout for the host <-> sound-CPU mailbox.
// Slot k lives at Z80 I/O address BASE + 2k.
package snd_mailbox_pkg;

  localparam int unsigned StatOvfBit = 7;

  // Width of a select bus for n items, never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] slot_out(input int unsigned k);
    return 8'(k);
  endfunction

  function automatic logic [7:0] slot_irq(input int unsigned nout);
    return 8'(nout);
  endfunction

  function automatic logic [7:0] slot_nmiclr(input int unsigned nout);
    return 8'(nout + 1);
  endfunction

  function automatic logic [7:0] slot_in(input int unsigned nout, input int unsigned i);
    return 8'(nout + 2 + i);
  endfunction

  function automatic logic [7:0] slot_status(input int unsigned nout, input int unsigned nin);
    return 8'(nout + nin + 2);
  endfunction

  function automatic logic [7:0] slot_count(input int unsigned nout, input int unsigned nin);
    return 8'(nout + nin + 3);
  endfunction

endpackage

// File: rtl/snd_mailbox_fifo.sv
// One inbound channel: an overwrite latch with a "fresh" flag, or a small
// push/pop FIFO that remembers the last popped byte for reads while empty.
module snd_mailbox_fifo #(
  parameter int unsigned DEPTH     = 1,
  parameter int unsigned FIFO_MODE = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_ovf_clr,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_ovf
);

  if (FIFO_MODE == 0) begin : g_latch
    logic [7:0] r_val;
    logic       r_new;
    logic       w_unused_clr;

    assign w_unused_clr = i_ovf_clr;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_val <= 8'h00;
        r_new <= 1'b0;
      end else begin
        if (i_push) r_val <= i_din;
        if (i_push)     r_new <= 1'b1;
        else if (i_pop) r_new <= 1'b0;
      end
    end

    assign o_dout  = r_val;
    assign o_empty = ~r_new;
    assign o_full  = r_new;
    assign o_ovf   = 1'b0;
  end else begin : g_fifo
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(DEPTH - 1);

    logic [7:0]      r_mem [2**PtrW];
    logic [PtrW-1:0] r_rd, r_wr;
    logic [CntW-1:0] r_cnt;
    logic [7:0]      r_last;
    logic            r_ovf;
    logic            w_empty, w_full, w_do_pop, w_do_push;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrMax) ? '0 : p + 1'b1;
    endfunction

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CntW'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_rd   <= '0;
        r_wr   <= '0;
        r_cnt  <= '0;
        r_last <= 8'h00;
        r_ovf  <= 1'b0;
      end else begin
        if (w_do_push) r_wr <= ptr_inc(r_wr);
        if (w_do_pop) begin
          r_rd   <= ptr_inc(r_rd);
          r_last <= r_mem[r_rd];
        end
        if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
        else if (!w_do_push && w_do_pop) r_cnt <= r_cnt - 1'b1;
        if (i_push && !w_do_push) r_ovf <= 1'b1;
        else if (i_ovf_clr)       r_ovf <= 1'b0;
      end
    end

    assign o_dout  = w_empty ? r_last : r_mem[r_rd];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_ovf   = r_ovf;
  end

endmodule

// File: rtl/snd_mailbox.sv
// Host <-> sound-CPU mailbox: inbound channels, outbound latches, host wait,
// NMI request and the periodic Z80 IRQ, all decoded from one I/O window.
module snd_mailbox
  import snd_mailbox_pkg::*;
#(
  parameter int unsigned NIN       = 2,
  parameter int unsigned NOUT      = 2,
  parameter int unsigned DEPTH     = 1,
  parameter int unsigned FIFO_MODE = 0,
  parameter logic [7:0]  BASE      = 8'h40,
  parameter int unsigned IRQ_DIV   = 12000
) (
  input  logic                     CLK96,
  input  logic                     RESET96,
  input  logic                     CEN,
  input  logic                     HOST_CS,
  input  logic                     HOST_WR,
  input  logic [sel_w(NIN)-1:0]    HOST_IDX,
  input  logic [7:0]               HOST_DIN,
  input  logic [sel_w(NOUT)-1:0]   HOST_RIDX,
  output logic [7:0]               HOST_DOUT,
  output logic                     HOST_WAIT,
  input  logic                     NMI_TRIG,
  output logic                     SNDIRQ,
  input  logic                     Z80_IORQ_N,
  input  logic                     Z80_M1_N,
  input  logic                     Z80_RD_N,
  input  logic                     Z80_WR_N,
  input  logic [7:0]               Z80_A,
  input  logic [7:0]               Z80_DOUT,
  output logic [7:0]               Z80_DIN,
  output logic                     Z80_HIT,
  output logic                     INT_N,
  output logic                     NMI_N
);

  localparam int unsigned IdxW = sel_w(NIN);
  localparam int unsigned CntW = $clog2(IRQ_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(IRQ_DIV - 1);
  localparam logic [7:0] SlotIrq    = slot_irq(NOUT);
  localparam logic [7:0] SlotNmiClr = slot_nmiclr(NOUT);
  localparam logic [7:0] SlotStatus = slot_status(NOUT, NIN);
  localparam logic [7:0] SlotCount  = slot_count(NOUT, NIN);

  logic            r_armed, r_cs_q, r_trig_q, r_acc_q;
  logic [7:0]      r_out [NOUT];
  logic [7:0]      r_din;
  logic            r_hit, r_wait, r_nmi_n, r_sndirq, r_int_n;
  logic [CntW-1:0] r_cnt;

  logic       w_acc, w_stb, w_dec, w_rd_stb, w_wr_stb, w_out_wr, w_stat_rd;
  logic       w_cs_rise, w_trig_rise, w_wrap, w_ack, w_rhit;
  logic [7:0] w_off, w_slot, w_status, w_rdata;
  logic [NIN-1:0] w_push, w_pop, w_empty, w_full, w_ovf;
  logic [7:0] w_fdout [NIN];
  logic       w_unused_full;

  // r_armed masks the first cycle after reset so inputs already high never look like edges.
  assign w_acc       = ~Z80_IORQ_N & Z80_M1_N & (~Z80_RD_N | ~Z80_WR_N);
  assign w_stb       = r_armed & w_acc & ~r_acc_q;
  assign w_cs_rise   = r_armed & HOST_CS & ~r_cs_q;
  assign w_trig_rise = r_armed & NMI_TRIG & ~r_trig_q;

  assign w_off     = Z80_A - BASE;
  assign w_slot    = {1'b0, w_off[7:1]};
  assign w_dec     = (Z80_A >= BASE) & ~w_off[0] & (w_slot < SlotCount);
  assign w_rd_stb  = w_stb & w_dec & ~Z80_RD_N;
  assign w_wr_stb  = w_stb & w_dec & ~Z80_WR_N;
  assign w_out_wr  = w_wr_stb & (w_slot < 8'(NOUT));
  assign w_stat_rd = w_rd_stb & (w_slot == SlotStatus);

  assign w_wrap = CEN & (r_cnt == CntMax);
  assign w_ack  = CEN & ~Z80_IORQ_N & ~Z80_M1_N;

  for (genvar i = 0; i < NIN; i++) begin : g_chan
    assign w_push[i] = HOST_WR & (HOST_IDX == IdxW'(i));
    assign w_pop[i]  = w_rd_stb & (w_slot == slot_in(NOUT, i));

    snd_mailbox_fifo #(
      .DEPTH     (DEPTH),
      .FIFO_MODE (FIFO_MODE)
    ) u_fifo (
      .i_clk     (CLK96),
      .i_rst     (RESET96),
      .i_push    (w_push[i]),
      .i_pop     (w_pop[i]),
      .i_ovf_clr (w_stat_rd),
      .i_din     (HOST_DIN),
      .o_dout    (w_fdout[i]),
      .o_empty   (w_empty[i]),
      .o_full    (w_full[i]),
      .o_ovf     (w_ovf[i])
    );
  end

  assign w_unused_full = ^w_full;

  always_comb begin
    w_status = 8'h00;
    w_status[StatOvfBit] = |w_ovf;
    for (int unsigned i = 0; i < NIN && i < StatOvfBit; i++) w_status[i] = ~w_empty[i];
  end

  always_comb begin
    w_rdata = 8'hFF;
    w_rhit  = 1'b0;
    if (w_slot == SlotStatus) begin
      w_rdata = w_status;
      w_rhit  = 1'b1;
    end
    for (int unsigned i = 0; i < NIN; i++) begin
      if (w_slot == slot_in(NOUT, i)) begin
        w_rdata = w_fdout[i];
        w_rhit  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      r_armed  <= 1'b0;
      r_cs_q   <= 1'b0;
      r_trig_q <= 1'b0;
      r_acc_q  <= 1'b0;
      for (int unsigned k = 0; k < NOUT; k++) r_out[k] <= 8'h00;
      r_din    <= 8'hFF;
      r_hit    <= 1'b0;
      r_wait   <= 1'b0;
      r_nmi_n  <= 1'b1;
      r_sndirq <= 1'b0;
      r_int_n  <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_armed  <= 1'b1;
      r_cs_q   <= HOST_CS;
      r_trig_q <= NMI_TRIG;
      r_acc_q  <= w_acc;
      // Read data is held for the whole access and parks at FF once IORQ_N rises.
      if (Z80_IORQ_N) begin
        r_din <= 8'hFF;
        r_hit <= 1'b0;
      end else if (w_rd_stb) begin
        r_din <= w_rdata;
        r_hit <= w_rhit;
      end
      for (int unsigned k = 0; k < NOUT; k++) begin
        if (w_out_wr && (w_slot == slot_out(k))) r_out[k] <= Z80_DOUT;
      end
      r_sndirq <= w_wr_stb & (w_slot == SlotIrq);
      if (w_cs_rise)     r_wait <= 1'b1;
      else if (w_out_wr) r_wait <= 1'b0;
      if (w_trig_rise) r_nmi_n <= 1'b0;
      else if (w_wr_stb && (w_slot == SlotNmiClr)) r_nmi_n <= 1'b1;
      if (CEN) r_cnt <= (r_cnt == CntMax) ? '0 : r_cnt + 1'b1;
      if (w_ack)       r_int_n <= 1'b1;
      else if (w_wrap) r_int_n <= 1'b0;
    end
  end

  assign HOST_DOUT = (32'(HOST_RIDX) < NOUT) ? r_out[HOST_RIDX] : 8'h00;
  assign HOST_WAIT = r_wait;
  assign SNDIRQ    = r_sndirq;
  assign Z80_DIN   = r_din;
  assign Z80_HIT   = r_hit;
  assign INT_N     = r_int_n;
  assign NMI_N     = r_nmi_n;

endmodule

// File: tb/tb_snd_mailbox.sv
// Bench for snd_mailbox: a latch-mode and a FIFO-mode instance share all inputs
// and are checked against queue/array models of the mailbox behaviour.
module tb_snd_mailbox;

  logic       CLK96 = 1'b0;
  logic       RESET96, CEN, HOST_CS, HOST_WR, NMI_TRIG;
  logic [0:0] HOST_IDX, HOST_RIDX;
  logic [7:0] HOST_DIN, Z80_A, Z80_DOUT;
  logic       Z80_IORQ_N, Z80_M1_N, Z80_RD_N, Z80_WR_N;

  logic [7:0] l_hdout, f_hdout, l_din, f_din;
  logic       l_wait, f_wait, l_snd, f_snd, l_hit, f_hit, l_int, f_int, l_nmi, f_nmi;

  int checks = 0;
  int failures = 0;

  // Models
  logic [7:0] m_lat_val [2];
  bit         m_lat_new [2];
  logic [7:0] m_q0 [$];
  logic [7:0] m_q1 [$];
  logic [7:0] m_last [2];
  bit         m_ovf;
  logic [7:0] m_out [2];

  // Samples from the last Z80 read
  logic [7:0] exp_l, exp_f, s_l_first, s_f_first, s_l_end, s_f_end;
  logic       s_l_hit, s_f_hit, s_l_snd, s_f_snd;

  always #5 CLK96 = ~CLK96;

  snd_mailbox #(.IRQ_DIV(4)) u_lat (
    .CLK96(CLK96), .RESET96(RESET96), .CEN(CEN), .HOST_CS(HOST_CS), .HOST_WR(HOST_WR),
    .HOST_IDX(HOST_IDX), .HOST_DIN(HOST_DIN), .HOST_RIDX(HOST_RIDX), .HOST_DOUT(l_hdout),
    .HOST_WAIT(l_wait), .NMI_TRIG(NMI_TRIG), .SNDIRQ(l_snd), .Z80_IORQ_N(Z80_IORQ_N),
    .Z80_M1_N(Z80_M1_N), .Z80_RD_N(Z80_RD_N), .Z80_WR_N(Z80_WR_N), .Z80_A(Z80_A),
    .Z80_DOUT(Z80_DOUT), .Z80_DIN(l_din), .Z80_HIT(l_hit), .INT_N(l_int), .NMI_N(l_nmi)
  );

  snd_mailbox #(.FIFO_MODE(1), .DEPTH(4), .IRQ_DIV(4)) u_fifo (
    .CLK96(CLK96), .RESET96(RESET96), .CEN(CEN), .HOST_CS(HOST_CS), .HOST_WR(HOST_WR),
    .HOST_IDX(HOST_IDX), .HOST_DIN(HOST_DIN), .HOST_RIDX(HOST_RIDX), .HOST_DOUT(f_hdout),
    .HOST_WAIT(f_wait), .NMI_TRIG(NMI_TRIG), .SNDIRQ(f_snd), .Z80_IORQ_N(Z80_IORQ_N),
    .Z80_M1_N(Z80_M1_N), .Z80_RD_N(Z80_RD_N), .Z80_WR_N(Z80_WR_N), .Z80_A(Z80_A),
    .Z80_DOUT(Z80_DOUT), .Z80_DIN(f_din), .Z80_HIT(f_hit), .INT_N(f_int), .NMI_N(f_nmi)
  );

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lat_val[i] = 8'h00;
      m_lat_new[i] = 1'b0;
      m_last[i]    = 8'h00;
      m_out[i]     = 8'h00;
    end
    m_q0.delete();
    m_q1.delete();
    m_ovf = 1'b0;
  endfunction

  function automatic void model_push(input int ch, input logic [7:0] d);
    m_lat_val[ch] = d;
    m_lat_new[ch] = 1'b1;
    if (ch == 0) begin
      if (m_q0.size() < 4) m_q0.push_back(d); else m_ovf = 1'b1;
    end else begin
      if (m_q1.size() < 4) m_q1.push_back(d); else m_ovf = 1'b1;
    end
  endfunction

  function automatic void model_read(input logic [7:0] addr, output logic [7:0] el,
                                     output logic [7:0] ef);
    el = 8'hFF;
    ef = 8'hFF;
    if (addr == 8'h48 || addr == 8'h4A) begin
      int ch = (addr == 8'h48) ? 0 : 1;
      el = m_lat_val[ch];
      m_lat_new[ch] = 1'b0;
      if (ch == 0 && m_q0.size() > 0) m_last[0] = m_q0.pop_front();
      if (ch == 1 && m_q1.size() > 0) m_last[1] = m_q1.pop_front();
      ef = m_last[ch];
    end else if (addr == 8'h4C) begin
      el = {6'b0, m_lat_new[1], m_lat_new[0]};
      ef = {m_ovf, 5'b0, m_q1.size() > 0, m_q0.size() > 0};
      m_ovf = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge CLK96);
    #1;
  endtask

  task automatic bus_idle();
    Z80_IORQ_N = 1'b1;
    Z80_M1_N   = 1'b1;
    Z80_RD_N   = 1'b1;
    Z80_WR_N   = 1'b1;
  endtask

  task automatic do_reset();
    RESET96 = 1'b1;
    HOST_WR = 1'b0;
    tick();
    tick();
    RESET96 = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic host_push(input int ch, input logic [7:0] d);
    HOST_IDX = ch[0:0];
    HOST_DIN = d;
    HOST_WR  = 1'b1;
    tick();
    HOST_WR  = 1'b0;
    model_push(ch, d);
  endtask

  task automatic z80_in(input logic [7:0] addr, input int hold);
    model_read(addr, exp_l, exp_f);
    Z80_A      = addr;
    Z80_IORQ_N = 1'b0;
    Z80_M1_N   = 1'b1;
    Z80_RD_N   = 1'b0;
    tick();
    s_l_first = l_din;
    s_f_first = f_din;
    s_l_hit   = l_hit;
    s_f_hit   = f_hit;
    repeat (hold - 1) tick();
    s_l_end = l_din;
    s_f_end = f_din;
    bus_idle();
    tick();
  endtask

  task automatic z80_out(input logic [7:0] addr, input logic [7:0] d);
    Z80_A      = addr;
    Z80_DOUT   = d;
    Z80_IORQ_N = 1'b0;
    Z80_M1_N   = 1'b1;
    Z80_WR_N   = 1'b0;
    tick();
    s_l_snd = l_snd;
    s_f_snd = f_snd;
    bus_idle();
    tick();
    if (addr == 8'h40) m_out[0] = d;
    if (addr == 8'h42) m_out[1] = d;
  endtask

  task automatic test_reset();
    bus_idle();
    CEN = 1'b0; HOST_WR = 1'b0; HOST_IDX = 1'b0; HOST_RIDX = 1'b0; HOST_DIN = 8'h00;
    Z80_A = 8'h00; Z80_DOUT = 8'h00;
    HOST_CS = 1'b1;
    NMI_TRIG = 1'b1;
    RESET96 = 1'b1;
    #2;
    tick();
    tick();
    RESET96 = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++;
    if ({l_wait, l_nmi, l_int, l_snd, l_hit} !== 5'b01100) begin
      failures++;
      $display("FAIL reset_flags_lat got=%b want=01100", {l_wait, l_nmi, l_int, l_snd, l_hit});
    end
    checks++;
    if ({f_wait, f_nmi, f_int, f_snd, f_hit} !== 5'b01100) begin
      failures++;
      $display("FAIL reset_flags_fifo got=%b want=01100", {f_wait, f_nmi, f_int, f_snd, f_hit});
    end
    checks++;
    if ({l_din, f_din} !== 16'hFFFF) begin
      failures++;
      $display("FAIL reset_din got=%h want=ffff", {l_din, f_din});
    end
    for (int r = 0; r < 2; r++) begin
      HOST_RIDX = r[0:0];
      #1;
      checks++;
      if ({l_hdout, f_hdout} !== 16'h0000) begin
        failures++;
        $display("FAIL reset_hdout%0d got=%h want=0000", r, {l_hdout, f_hdout});
      end
    end
    HOST_CS = 1'b0;
    NMI_TRIG = 1'b0;
    tick();
  endtask

  task automatic test_latch_basic();
    do_reset();
    host_push(0, 8'h5A);
    z80_in(8'h4C, 1);
    checks++;
    if ({s_l_first, s_f_first} !== 16'h0101) begin
      failures++;
      $display("FAIL basic_status1 got=%h want=0101", {s_l_first, s_f_first});
    end
    z80_in(8'h48, 1);
    checks++;
    if ({s_l_first, s_f_first, s_l_hit, s_f_hit} !== {16'h5A5A, 2'b11}) begin
      failures++;
      $display("FAIL basic_read1 got=%h hit=%b%b want=5a5a hit=11", {s_l_first, s_f_first},
               s_l_hit, s_f_hit);
    end
    checks++;
    if ({l_din, f_din, l_hit, f_hit} !== {16'hFFFF, 2'b00}) begin
      failures++;
      $display("FAIL basic_idle got=%h hit=%b%b want=ffff hit=00", {l_din, f_din}, l_hit, f_hit);
    end
    z80_in(8'h48, 1);
    checks++;
    if ({s_l_first, s_f_first} !== 16'h5A5A) begin
      failures++;
      $display("FAIL basic_read2 got=%h want=5a5a", {s_l_first, s_f_first});
    end
    z80_in(8'h4C, 1);
    checks++;
    if ({s_l_first, s_f_first} !== 16'h0000) begin
      failures++;
      $display("FAIL basic_status2 got=%h want=0000", {s_l_first, s_f_first});
    end
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] want;
    do_reset();
    for (int i = 1; i <= 5; i++) host_push(0, 8'(i));
    for (int i = 1; i <= 5; i++) begin
      z80_in(8'h48, 1);
      want = (i == 5) ? 8'd4 : 8'(i);
      checks++;
      if ({s_l_first, s_f_first} !== {8'd5, want}) begin
        failures++;
        $display("FAIL ovf_read%0d got=%h want=%h", i, {s_l_first, s_f_first}, {8'd5, want});
      end
    end
    z80_in(8'h4C, 1);
    checks++;
    if ({s_l_first, s_f_first} !== 16'h0080) begin
      failures++;
      $display("FAIL ovf_status1 got=%h want=0080", {s_l_first, s_f_first});
    end
    z80_in(8'h4C, 1);
    checks++;
    if (s_f_first !== 8'h00) begin
      failures++;
      $display("FAIL ovf_status2 got=%h want=00", s_f_first);
    end
  endtask

  task automatic test_long_read();
    do_reset();
    host_push(0, 8'h11);
    host_push(0, 8'h22);
    z80_in(8'h48, 12);
    checks++;
    if ({s_f_first, s_f_end} !== 16'h1111) begin
      failures++;
      $display("FAIL long_read got=%h want=1111", {s_f_first, s_f_end});
    end
    z80_in(8'h48, 1);
    checks++;
    if (s_f_first !== 8'h22) begin
      failures++;
      $display("FAIL long_next got=%h want=22", s_f_first);
    end
    host_push(1, 8'h33);
    host_push(1, 8'h44);
    Z80_A = 8'h4A; Z80_IORQ_N = 1'b0; Z80_RD_N = 1'b0;
    tick();
    RESET96 = 1'b1;
    #1;
    checks++;
    if ({l_din, f_din, l_hit, f_hit} !== {16'hFFFF, 2'b00}) begin
      failures++;
      $display("FAIL async_reset got=%h hit=%b%b want=ffff hit=00", {l_din, f_din}, l_hit, f_hit);
    end
    bus_idle();
    tick();
    RESET96 = 1'b0;
    model_reset();
    tick();
    z80_in(8'h4C, 1);
    checks++;
    if ({s_l_first, s_f_first} !== 16'h0000) begin
      failures++;
      $display("FAIL reset_status got=%h want=0000", {s_l_first, s_f_first});
    end
  endtask

  task automatic test_wait_out();
    do_reset();
    HOST_CS = 1'b1;
    tick();
    checks++;
    if ({l_wait, f_wait} !== 2'b11) begin
      failures++;
      $display("FAIL wait_set got=%b want=11", {l_wait, f_wait});
    end
    z80_out(8'h42, 8'hC3);
    HOST_RIDX = 1'b1;
    #1;
    checks++;
    if ({l_wait, f_wait, l_hdout, f_hdout} !== {2'b00, 16'hC3C3}) begin
      failures++;
      $display("FAIL wait_clear got=%b dout=%h want=00 dout=c3c3", {l_wait, f_wait},
               {l_hdout, f_hdout});
    end
    HOST_CS = 1'b0;
    tick();
    HOST_CS = 1'b1;
    Z80_A = 8'h40; Z80_DOUT = 8'hA5; Z80_IORQ_N = 1'b0; Z80_WR_N = 1'b0;
    tick();
    bus_idle();
    tick();
    HOST_RIDX = 1'b0;
    #1;
    checks++;
    if ({l_wait, f_wait, l_hdout, f_hdout} !== {2'b11, 16'hA5A5}) begin
      failures++;
      $display("FAIL wait_set_wins got=%b dout=%h want=11 dout=a5a5", {l_wait, f_wait},
               {l_hdout, f_hdout});
    end
    HOST_CS = 1'b0;
  endtask

  task automatic test_nmi_sndirq();
    do_reset();
    NMI_TRIG = 1'b1;
    tick();
    NMI_TRIG = 1'b0;
    tick();
    checks++;
    if ({l_nmi, f_nmi} !== 2'b00) begin
      failures++;
      $display("FAIL nmi_set got=%b want=00", {l_nmi, f_nmi});
    end
    z80_out(8'h46, 8'h00);
    checks++;
    if ({l_nmi, f_nmi} !== 2'b11) begin
      failures++;
      $display("FAIL nmi_clear got=%b want=11", {l_nmi, f_nmi});
    end
    z80_out(8'h44, 8'h00);
    checks++;
    if ({s_l_snd, s_f_snd, l_snd, f_snd} !== 4'b1100) begin
      failures++;
      $display("FAIL sndirq_pulse got=%b want=1100", {s_l_snd, s_f_snd, l_snd, f_snd});
    end
    NMI_TRIG = 1'b1;
    Z80_A = 8'h46; Z80_IORQ_N = 1'b0; Z80_WR_N = 1'b0;
    tick();
    bus_idle();
    NMI_TRIG = 1'b0;
    tick();
    checks++;
    if ({l_nmi, f_nmi} !== 2'b00) begin
      failures++;
      $display("FAIL nmi_set_wins got=%b want=00", {l_nmi, f_nmi});
    end
  endtask

  task automatic test_irq();
    int  ticks;
    bit  m_int;
    bit  cen, ack;
    do_reset();
    ticks = 0;
    m_int = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      cen = (cyc % 2 == 0);
      // Force one acknowledge exactly on a wrapping tick.
      ack = (cen && ticks % 4 == 3 && ticks / 4 == 2) || ($urandom_range(0, 5) == 0);
      CEN = cen;
      Z80_IORQ_N = ~ack;
      Z80_M1_N = ~ack;
      tick();
      if (cen) begin
        ticks++;
        if (ack) m_int = 1'b1;
        else if (ticks % 4 == 0) m_int = 1'b0;
      end
      checks++;
      if ({l_int, f_int} !== {m_int, m_int}) begin
        failures++;
        $display("FAIL irq_cyc%0d got=%b want=%b%b", cyc, {l_int, f_int}, m_int, m_int);
      end
    end
    CEN = 1'b0;
    bus_idle();
    tick();
  endtask

  task automatic test_random();
    int op, ch;
    logic [7:0] d;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 3);
      ch = $urandom_range(0, 1);
      d  = 8'($urandom);
      if (op == 0) begin
        host_push(ch, d);
      end else if (op == 1) begin
        z80_in((ch == 0) ? 8'h48 : 8'h4A, $urandom_range(1, 3));
        checks++;
        if ({s_l_first, s_f_first, s_f_end} !== {exp_l, exp_f, exp_f}) begin
          failures++;
          $display("FAIL rand_read%0d ch%0d got=%h want=%h", n, ch,
                   {s_l_first, s_f_first, s_f_end}, {exp_l, exp_f, exp_f});
        end
      end else if (op == 2) begin
        z80_in(8'h4C, 1);
        checks++;
        if ({s_l_first, s_f_first} !== {exp_l, exp_f}) begin
          failures++;
          $display("FAIL rand_status%0d got=%h want=%h", n, {s_l_first, s_f_first},
                   {exp_l, exp_f});
        end
      end else begin
        z80_out((ch == 0) ? 8'h40 : 8'h42, d);
        HOST_RIDX = ch[0:0];
        #1;
        checks++;
        if ({l_hdout, f_hdout} !== {m_out[ch], m_out[ch]}) begin
          failures++;
          $display("FAIL rand_out%0d ch%0d got=%h want=%h", n, ch, {l_hdout, f_hdout},
                   {m_out[ch], m_out[ch]});
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latch_basic();
    test_fifo_overflow();
    test_long_read();
    test_wait_out();
    test_nmi_sndirq();
    test_irq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
